// File: rtl/des_sram_ctrl.sv
// Transaction sequencer for the I2C Triple-DES datapath: key loads, data capture,
// DES start/finish handshakes and a circular SRAM block buffer with independent pointers.
module des_sram_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int NUM_KEYS  = 2,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                i2c_stop,
    input  logic                i2c_rw,
    input  logic                data_ready,
    input  logic                next_data,
    input  logic                des_ready,
    output logic [NUM_KEYS-1:0] key_act,
    output logic                data_load,
    output logic                des_start,
    output logic                dir_sel,
    output logic                write_enable,
    output logic                read_enable,
    output logic                output_load_enable,
    output logic [ADDR_W-1:0]   address,
    output logic [ADDR_W:0]     count,
    output logic                overflow,
    output logic                underflow,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE, KEY, DATA, CRYPT, WAIT_DES, STORE, READ, LOAD_OUT
    } state_t;

    localparam logic [ADDR_W-1:0]   BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]   LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]   PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]     FULL     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]     CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [NUM_KEYS-1:0] KEY_LSB  = NUM_KEYS'(1);
    localparam logic [2:0]          LAST_KEY = 3'(NUM_KEYS - 1);

    state_t              state_q, state_d;
    logic [2:0]          k_q, k_d;
    logic                stop_pending, stop_d;
    logic [ADDR_W-1:0]   wr_ptr, wr_d;
    logic [ADDR_W-1:0]   rd_ptr, rd_d;
    logic [ADDR_W:0]     count_d;
    logic                mode_d, ovf_d;
    logic [NUM_KEYS-1:0] key_act_d;
    logic                data_load_d, des_start_d, we_d, re_d, ole_d, underflow_d, busy_d;
    logic [ADDR_W-1:0]   address_d;

    // Handshake: every input is a level sampled on the rising edge; every strobe output
    // is registered, appears in the cycle after the sampling edge and lasts one cycle.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        stop_d      = stop_pending;
        wr_d        = wr_ptr;
        rd_d        = rd_ptr;
        count_d     = count;
        mode_d      = dir_sel;
        ovf_d       = overflow;
        key_act_d   = '0;
        data_load_d = 1'b0;
        des_start_d = 1'b0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        ole_d       = 1'b0;
        underflow_d = 1'b0;

        // A stop during block processing is deferred until the block has finished.
        if (i2c_stop && (state_q == READ || state_q == CRYPT || state_q == WAIT_DES ||
                         state_q == STORE || state_q == LOAD_OUT))
            stop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (data_ready && !i2c_stop) begin
                    mode_d    = i2c_rw;
                    key_act_d = KEY_LSB;
                    k_d       = 3'd1;
                    state_d   = (NUM_KEYS == 1) ? DATA : KEY;
                end
            end
            KEY: begin
                if (i2c_stop) begin
                    state_d = IDLE;
                end else if (data_ready) begin
                    key_act_d = KEY_LSB << k_q;
                    k_d       = k_q + 3'd1;
                    if (k_q == LAST_KEY)
                        state_d = DATA;
                end
            end
            DATA: begin
                if (i2c_stop) begin
                    state_d = IDLE;
                end else if (!dir_sel) begin
                    if (data_ready)
                        data_load_d = 1'b1;
                    if (next_data) begin
                        state_d     = CRYPT;
                        des_start_d = 1'b1;
                    end
                end else if (next_data) begin
                    if (count == '0) begin
                        underflow_d = 1'b1;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end
                end
            end
            READ: begin
                state_d     = CRYPT;
                des_start_d = 1'b1;
            end
            CRYPT: state_d = WAIT_DES;
            WAIT_DES: begin
                if (des_ready) begin
                    if (!dir_sel) begin
                        state_d = STORE;
                        if (count < FULL)
                            we_d = 1'b1;
                        else
                            ovf_d = 1'b1;
                    end else begin
                        state_d = LOAD_OUT;
                        ole_d   = 1'b1;
                    end
                end
            end
            STORE: begin
                // write_enable is high during STORE exactly when the slot was written.
                if (write_enable) begin
                    wr_d    = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
                    count_d = count + CNT_ONE;
                end
                state_d = (stop_pending || i2c_stop) ? IDLE : DATA;
            end
            LOAD_OUT: begin
                rd_d    = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
                count_d = count - CNT_ONE;
                state_d = (stop_pending || i2c_stop) ? IDLE : DATA;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            k_d    = 3'd0;
            stop_d = 1'b0;
        end

        busy_d    = (state_d != IDLE);
        address_d = BASE + (((state_d == IDLE) ? i2c_rw : mode_d) ? rd_d : wr_d);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q            <= IDLE;
            k_q                <= 3'd0;
            stop_pending       <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            dir_sel            <= 1'b0;
            overflow           <= 1'b0;
            key_act            <= '0;
            data_load          <= 1'b0;
            des_start          <= 1'b0;
            write_enable       <= 1'b0;
            read_enable        <= 1'b0;
            output_load_enable <= 1'b0;
            underflow          <= 1'b0;
            busy               <= 1'b0;
            address            <= BASE;
        end else begin
            state_q            <= state_d;
            k_q                <= k_d;
            stop_pending       <= stop_d;
            wr_ptr             <= wr_d;
            rd_ptr             <= rd_d;
            count              <= count_d;
            dir_sel            <= mode_d;
            overflow           <= ovf_d;
            key_act            <= key_act_d;
            data_load          <= data_load_d;
            des_start          <= des_start_d;
            write_enable       <= we_d;
            read_enable        <= re_d;
            output_load_enable <= ole_d;
            underflow          <= underflow_d;
            busy               <= busy_d;
            address            <= address_d;
        end
    end

endmodule

// File: tb/tb_des_sram_ctrl.sv
// Self-checking bench for des_sram_ctrl: scenario tasks plus an SRAM-access scoreboard.
module tb_des_sram_ctrl;

    localparam int ADDR_W    = 16;
    localparam int NUM_KEYS  = 2;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 16'h0100;
    localparam int W         = ADDR_W + 2;

    logic                clk;
    logic                n_rst;
    logic                i2c_stop;
    logic                i2c_rw;
    logic                data_ready;
    logic                next_data;
    logic                des_ready;
    logic [NUM_KEYS-1:0] key_act;
    logic                data_load;
    logic                des_start;
    logic                dir_sel;
    logic                write_enable;
    logic                read_enable;
    logic                output_load_enable;
    logic [ADDR_W-1:0]   address;
    logic [ADDR_W:0]     count;
    logic                overflow;
    logic                underflow;
    logic                busy;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {write_enable, read_enable, address}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    int   mdl_count = 0;
    int   mdl_wr    = 0;
    int   mdl_rd    = 0;
    logic mdl_ovf   = 1'b0;

    int key_cnt = 0;
    int dl_cnt  = 0;
    int ds_cnt  = 0;
    int ole_cnt = 0;

    des_sram_ctrl #(
        .ADDR_W   (ADDR_W),
        .NUM_KEYS (NUM_KEYS),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .i2c_stop          (i2c_stop),
        .i2c_rw            (i2c_rw),
        .data_ready        (data_ready),
        .next_data         (next_data),
        .des_ready         (des_ready),
        .key_act           (key_act),
        .data_load         (data_load),
        .des_start         (des_start),
        .dir_sel           (dir_sel),
        .write_enable      (write_enable),
        .read_enable       (read_enable),
        .output_load_enable(output_load_enable),
        .address           (address),
        .count             (count),
        .overflow          (overflow),
        .underflow         (underflow),
        .busy              (busy)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        n_rst      = 1'b0;
        i2c_stop   = 1'b0;
        i2c_rw     = 1'b0;
        data_ready = 1'b0;
        next_data  = 1'b0;
        des_ready  = 1'b0;
    end

    // Monitor: strobe counters and SRAM access scoreboard
    always @(negedge clk) begin
        if (key_act != '0) key_cnt++;
        if (data_load) dl_cnt++;
        if (des_start) ds_cnt++;
        if (output_load_enable) ole_cnt++;
        if (write_enable || read_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sram_access: got we=%0b re=%0b addr=%h, expected no access",
                         write_enable, read_enable, address);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({write_enable, read_enable, address} !== mon_exp) begin
                    errors++;
                    $display("FAIL sram_access: got {we,re,addr}=%h, expected %h",
                             {write_enable, read_enable, address}, mon_exp);
                end
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic dr, input logic nd, input logic dsr, input logic stp);
        @(negedge clk);
        data_ready = dr;
        next_data  = nd;
        des_ready  = dsr;
        i2c_stop   = stp;
        @(negedge clk);
        data_ready = 1'b0;
        next_data  = 1'b0;
        des_ready  = 1'b0;
        i2c_stop   = 1'b0;
        #1;
    endtask

    task automatic reset_model();
        mdl_count = 0;
        mdl_wr    = 0;
        mdl_rd    = 0;
        mdl_ovf   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        n_rst = 1'b0;
        idle(2);
        @(negedge clk);
        n_rst = 1'b1;
        reset_model();
        #1;
    endtask

    task automatic start_txn(input logic rw);
        i2c_rw = rw;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (key_act !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL key0: key_act=%b busy=%b, expected 01 and 1", key_act, busy);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (key_act !== 2'b10) begin
            errors++;
            $display("FAIL key1: key_act=%b, expected 10", key_act);
        end
        checks++;
        if (dir_sel !== rw) begin
            errors++;
            $display("FAIL dir_sel: got %b, expected %b", dir_sel, rw);
        end
    endtask

    task automatic write_block();
        logic exp_we;
        exp_we = (mdl_count < DEPTH);
        if (exp_we) exp_q.push_back({2'b10, ADDR_W'(BASE_ADDR + mdl_wr)});
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (des_start !== 1'b1) begin
            errors++;
            $display("FAIL des_start_wr: got %b, expected 1", des_start);
        end
        idle($urandom_range(0, 3));
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (write_enable !== exp_we) begin
            errors++;
            $display("FAIL write_enable: got %b, expected %b", write_enable, exp_we);
        end
        if (exp_we) begin
            mdl_wr = (mdl_wr + 1) % DEPTH;
            mdl_count++;
        end else begin
            mdl_ovf = 1'b1;
        end
        idle(1);
        checks++;
        if (count !== (ADDR_W + 1)'(mdl_count) || overflow !== mdl_ovf) begin
            errors++;
            $display("FAIL store_update: count=%0d overflow=%b, expected %0d and %b",
                     count, overflow, mdl_count, mdl_ovf);
        end
    endtask

    task automatic read_block();
        int ds0;
        ds0 = ds_cnt;
        if (mdl_count == 0) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (underflow !== 1'b1 || read_enable !== 1'b0) begin
                errors++;
                $display("FAIL underflow: underflow=%b read_enable=%b, expected 1 and 0",
                         underflow, read_enable);
            end
            idle(2);
            checks++;
            if (underflow !== 1'b0 || ds_cnt != ds0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL underflow_after: underflow=%b des_starts=%0d busy=%b, expected 0 0 1",
                         underflow, ds_cnt - ds0, busy);
            end
        end else begin
            exp_q.push_back({2'b01, ADDR_W'(BASE_ADDR + mdl_rd)});
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (read_enable !== 1'b1) begin
                errors++;
                $display("FAIL read_enable: got %b, expected 1", read_enable);
            end
            idle(1);
            checks++;
            if (des_start !== 1'b1) begin
                errors++;
                $display("FAIL des_start_rd: got %b, expected 1", des_start);
            end
            idle($urandom_range(0, 3));
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (output_load_enable !== 1'b1) begin
                errors++;
                $display("FAIL output_load: got %b, expected 1", output_load_enable);
            end
            mdl_rd = (mdl_rd + 1) % DEPTH;
            mdl_count--;
            idle(1);
            checks++;
            if (count !== (ADDR_W + 1)'(mdl_count)) begin
                errors++;
                $display("FAIL read_count: got %0d, expected %0d", count, mdl_count);
            end
        end
    endtask

    // Scenarios
    task automatic test_reset();
        n_rst = 1'b0;
        idle(3);
        checks++;
        if ({key_act, data_load, des_start, write_enable, read_enable, output_load_enable} !== '0) begin
            errors++;
            $display("FAIL reset_strobes: key=%b dl=%b ds=%b we=%b re=%b ole=%b, expected all 0",
                     key_act, data_load, des_start, write_enable, read_enable, output_load_enable);
        end
        checks++;
        if (address !== 16'h0100) begin
            errors++;
            $display("FAIL reset_address: got %h, expected 0100", address);
        end
        checks++;
        if (count !== '0 || {dir_sel, overflow, underflow, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: count=%0d dir=%b ovf=%b unf=%b busy=%b, expected all 0",
                     count, dir_sel, overflow, underflow, busy);
        end
        @(negedge clk);
        n_rst = 1'b1;
        reset_model();
        #1;
    endtask

    task automatic test_write();
        start_txn(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (data_load !== 1'b1) begin
            errors++;
            $display("FAIL data_load: got %b, expected 1", data_load);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (write_enable !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL des_ready_in_data: we=%b busy=%b, expected 0 and 1", write_enable, busy);
        end
        write_block();
        checks++;
        if (dir_sel !== 1'b0) begin
            errors++;
            $display("FAIL write_dir: got %b, expected 0", dir_sel);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_stop: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        start_txn(1'b0);
        repeat (5) write_block();
        checks++;
        if (overflow !== 1'b1 || count !== 17'd4) begin
            errors++;
            $display("FAIL fill: overflow=%b count=%0d, expected 1 and 4", overflow, count);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky: overflow=%b busy=%b, expected 1 and 0", overflow, busy);
        end
    endtask

    task automatic test_read_wrap();
        int ole0;
        ole0 = ole_cnt;
        start_txn(1'b1);
        i2c_rw = 1'b0;
        repeat (4) read_block();
        checks++;
        if (address !== 16'h0100 || dir_sel !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL read_wrap: addr=%h dir=%b count=%0d, expected 0100 1 0",
                     address, dir_sel, count);
        end
        checks++;
        if (ole_cnt - ole0 != 4) begin
            errors++;
            $display("FAIL output_load_count: got %0d, expected 4", ole_cnt - ole0);
        end
        read_block();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_stop: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_stop_mid_block();
        start_txn(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b10, ADDR_W'(BASE_ADDR + mdl_wr)});
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_wait_busy: busy=%b, expected 1", busy);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (write_enable !== 1'b1) begin
            errors++;
            $display("FAIL stop_store: write_enable=%b, expected 1", write_enable);
        end
        mdl_wr = (mdl_wr + 1) % DEPTH;
        mdl_count++;
        idle(1);
        checks++;
        if (busy !== 1'b0 || count !== (ADDR_W + 1)'(mdl_count)) begin
            errors++;
            $display("FAIL stop_idle: busy=%b count=%0d, expected 0 and %0d", busy, count, mdl_count);
        end
    endtask

    task automatic test_stop_with_data();
        int k0;
        i2c_rw = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0 || key_act !== '0) begin
            errors++;
            $display("FAIL idle_stop: busy=%b key_act=%b, expected 0 and 00", busy, key_act);
        end
        k0 = key_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (key_act !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL key_stop: key_act=%b busy=%b, expected 00 and 0", key_act, busy);
        end
        idle(1);
        checks++;
        if (key_cnt - k0 != 1) begin
            errors++;
            $display("FAIL key_stop_pulses: got %0d, expected 1", key_cnt - k0);
        end
    endtask

    task automatic test_reset_mid_op();
        start_txn(1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || count !== '0 || overflow !== 1'b0 || address !== 16'h0100) begin
            errors++;
            $display("FAIL reset_mid: busy=%b count=%0d ovf=%b addr=%h, expected 0 0 0 0100",
                     busy, count, overflow, address);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (write_enable !== 1'b0 || dir_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_store: we=%b dir=%b, expected 0 and 0", write_enable, dir_sel);
        end
        @(negedge clk);
        n_rst = 1'b1;
        reset_model();
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write();
        test_fill_overflow();
        test_read_wrap();
        test_stop_mid_block();
        test_stop_with_data();
        test_reset_mid_op();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_accesses: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: bench did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_sram_ctrl.md
# des_sram_ctrl

Parametrised main controller for the I2C Triple-DES datapath. It sequences a configurable number of key loads, per-block data capture, DES start/completion handshakes and SRAM accesses. The SRAM is managed as a circular block buffer with separate write and read pointers, so one transaction can carry a multi-block burst instead of a single block. It sits between the I2C slave front end (`i2c_stop`, `i2c_rw`, `data_ready`, `next_data`), the DES core (`des_ready`) and the SRAM.

## Interface
- `ADDR_W`, 16: SRAM address width.
- `NUM_KEYS`, 2: key loads per transaction, legal range 1..4.
- `DEPTH`, 4096: buffer capacity in blocks, with 1 ≤ `DEPTH` ≤ 2^`ADDR_W` − `BASE_ADDR`.
- `BASE_ADDR`, 0: SRAM address of buffer slot 0.

Ports:
- `clk`  in  1: single clock, rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `i2c_stop`  in  1: end-of-transaction pulse.
- `i2c_rw`  in  1: 0 = write/encrypt/store; 1 = read/decrypt/output.
- `data_ready`  in  1: a 64-bit word is available from I2C.
- `next_data`  in  1: master requests processing of the next block.
- `des_ready`  in  1: DES core has finished.
- `key_act`  out  `NUM_KEYS`: one-hot key-register load strobes.
- `data_load`  out  1: data-register load strobe.
- `des_start`  out  1: DES start strobe.
- `dir_sel`  out  1: 0 = encrypt, 1 = decrypt.
- `write_enable`  out  1: SRAM write strobe.
- `read_enable`  out  1: SRAM read strobe.
- `output_load_enable`  out  1: load DES result into the I2C output register.
- `address`  out  `ADDR_W`: SRAM address.
- `count`  out  `ADDR_W`+1: number of blocks stored.
- `overflow`  out  1: sticky flag, cleared only by reset.
- `underflow`  out  1: one-cycle pulse.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, KEY, DATA, CRYPT, WAIT_DES, STORE, READ, LOAD_OUT.
- IDLE, on `data_ready`:
  - Latch `mode` = `i2c_rw`.
  - Assert `key_act[0]` and set key index k = 1.
  - Go to KEY, or go directly to DATA when `NUM_KEYS` = 1.
  - `i2c_rw` is ignored outside this capture.
- KEY, on `data_ready`: pulse `key_act[k]` and increment k. After key `NUM_KEYS`−1, go to DATA.
- DATA, write mode:
  - `data_ready` pulses `data_load`.
  - `next_data` goes to CRYPT.
  - If a `next_data` arrives with no `data_load` since the last block, the previous data register is re-used.
- DATA, read mode:
  - `next_data` with `count` = 0: pulse `underflow` and stay in DATA. No SRAM or DES activity.
  - `next_data` with `count` > 0: go to READ.
- READ: pulse `read_enable` with `address` = `BASE_ADDR` + `rd_ptr`, then go to CRYPT.
- CRYPT: pulse `des_start` for one cycle, then go to WAIT_DES.
- WAIT_DES: wait for `des_ready`, then:
  - Write mode: go to STORE.
  - Read mode: go to LOAD_OUT.
- STORE:
  - If `count` < `DEPTH`: pulse `write_enable` at `BASE_ADDR` + `wr_ptr`, then `wr_ptr`++ and `count`++.
  - Otherwise: no write, pointer unchanged, set `overflow`.
  - Then return to DATA.
- LOAD_OUT: pulse `output_load_enable`, then `rd_ptr`++ and `count`−−, then return to DATA.
- Pointer wrap: a pointer equal to `DEPTH`−1 increments to 0.
- `address` value:
  - `BASE_ADDR` + `wr_ptr` in write mode.
  - `BASE_ADDR` + `rd_ptr` in read mode.
  - In IDLE, follows `i2c_rw`.
- `dir_sel` = `mode`, held stable for the whole transaction.
- `i2c_stop` handling:
  - In KEY or DATA: go to IDLE on the next edge. Stop has priority over a simultaneous `data_ready` or `next_data`.
  - In IDLE: ignored, and no transition even if `data_ready` is simultaneous.
  - In READ, CRYPT, WAIT_DES, STORE or LOAD_OUT: set `stop_pending`. The current block completes, including its STORE or LOAD_OUT, then the FSM goes to IDLE instead of DATA.
- Pointers and `count` persist across transactions. Key index k and `stop_pending` clear on entering IDLE.

## Timing
- Reset values:
  - State IDLE, k = 0.
  - `wr_ptr` = `rd_ptr` = 0, `count` = 0.
  - `address` = `BASE_ADDR`.
  - All strobes, `dir_sel`, `overflow`, `underflow`, `busy` = 0.
- All outputs are registered.
- An input sampled at edge n produces its strobe during cycle n+1. Every strobe is exactly one cycle wide.
- Write block, from `next_data` at edge n:
  - `des_start` in cycle n+1.
  - `des_ready` is first sampled at edge n+2.
  - If `des_ready` is sampled at edge m, `write_enable` is in cycle m+1 and DATA is re-entered at m+2.
- Read block, from `next_data` at edge n:
  - `read_enable` in cycle n+1.
  - `des_start` in cycle n+2.
  - If `des_ready` is sampled at edge m, `output_load_enable` is in cycle m+1.
- `des_ready` is ignored outside WAIT_DES.
- `count` and the pointer update at the edge that ends STORE or LOAD_OUT.
- Reset asserted mid-operation clears everything immediately. No SRAM strobe may occur after `n_rst` falls.

## Test plan
Parameters for all scenarios: `NUM_KEYS`=2, `DEPTH`=4, `BASE_ADDR`=16'h0100.

- **Reset check:** hold `n_rst`=0 → all outputs are 0 and `address`=16'h0100.
- **Write transaction:** `i2c_rw`=0; `data_ready` ×3, then `next_data`, then `des_ready` 3 cycles later → `key_act`=01, then 10; `data_load`; `des_start`; `write_enable` at 16'h0100; `count`=1; `dir_sel`=0. A following `i2c_stop` leads to IDLE with `busy`=0.
- **Fill and overflow:** five write blocks in one transaction → writes at 16'h0100–16'h0103; the fifth block produces no `write_enable`, `overflow`=1, `count`=4.
- **Read and wrap:** `i2c_rw`=1; two keys; four `next_data`, each followed by `des_ready` → `read_enable` at 16'h0100–16'h0103; `dir_sel`=1; four `output_load_enable` pulses; `count`=0; `rd_ptr` wraps to 0. A fifth `next_data` produces `underflow` and no `read_enable`.
- **Stop mid-block:** assert `i2c_stop` in WAIT_DES, then give `des_ready` → `write_enable` still occurs, then IDLE.
- **Stop with data:** `i2c_stop` together with `data_ready` in KEY → IDLE, and no `key_act` pulse.
